// File: rtl/selen_cpu_pkg.sv
// Shared CPU definitions: data width, NOP encoding, default reset PC and the
// prefetch buffer entry layout.
package selen_cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO between the instruction bus and the decode register.
// Push while full is accepted only together with a pop.
module fetch_buffer
   import selen_cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_clear,
   input  fetch_entry_t               i_entry,
   output fetch_entry_t               o_head,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   fetch_entry_t    r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [AW:0]     r_count;
   logic            w_full;
   logic            w_push_ok;
   logic            w_pop_ok;

   assign o_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_FULL);
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!w_full || w_pop_ok);
   assign o_head    = r_mem[r_rptr];
   assign o_count   = r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
         if (w_push_ok && !w_pop_ok)
            r_count <= r_count + 1'b1;
         else if (!w_push_ok && w_pop_ok)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok && !i_clear)
         r_mem[r_wptr] <= i_entry;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding bus requester feeding a prefetch
// buffer, plus the decode-stage instruction register.
//
//   state | meaning
//   IDLE  | no request outstanding
//   REQ   | strobe high, waiting for ack
//   DROP  | request outstanding, its response will be discarded
module fetch_stage
   import selen_cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enbD,
   input  logic            flashD,
   input  logic            redirect_in,
   input  logic [XLEN-1:0] redirect_pc_in,
   output logic [XLEN-1:0] inst_addr_out,
   output logic            inst_stb_out,
   input  logic            inst_ack_in,
   input  logic [XLEN-1:0] inst_data_in,
   output logic            inst_stall_out,
   output logic [XLEN-1:0] instD,
   output logic [XLEN-1:0] pcD,
   output logic            validD
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(BUF_DEPTH - 1);

   logic [1:0]      r_state;
   logic [XLEN-1:0] r_fetch_pc;
   logic            r_stb;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_instD;
   logic [XLEN-1:0] r_pcD;
   logic            r_validD;

   fetch_entry_t    w_head;
   fetch_entry_t    w_entry;
   logic            w_buf_empty;
   logic [CW-1:0]   w_buf_count;
   logic            w_push;
   logic            w_pop;
   logic            w_room;
   logic            w_room_after_push;

   assign w_pop  = !redirect_in && !flashD && !enbD && !w_buf_empty;
   assign w_push = (r_state == ST_REQ) && inst_ack_in && !redirect_in;

   assign w_entry.pc   = r_fetch_pc;
   assign w_entry.inst = inst_data_in;

   // Issue decisions look at the registered occupancy; a pop this cycle only
   // counts toward keeping back-to-back requests going after an ack.
   assign w_room            = (w_buf_count < CNT_FULL);
   assign w_room_after_push = w_pop || (w_buf_count < CNT_LAST);

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (redirect_in),
      .i_entry (w_entry),
      .o_head  (w_head),
      .o_empty (w_buf_empty),
      .o_count (w_buf_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC;
         r_stb      <= 1'b0;
         r_addr     <= RESET_PC;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (redirect_in) begin
                  r_fetch_pc <= redirect_pc_in;
               end else if (w_room) begin
                  r_state <= ST_REQ;
                  r_stb   <= 1'b1;
                  r_addr  <= r_fetch_pc;
               end
            end
            ST_REQ: begin
               if (redirect_in) begin
                  r_fetch_pc <= redirect_pc_in;
                  if (inst_ack_in) begin
                     r_state <= ST_IDLE;
                     r_stb   <= 1'b0;
                  end else begin
                     r_state <= ST_DROP;
                  end
               end else if (inst_ack_in) begin
                  r_fetch_pc <= pc_next(r_fetch_pc);
                  if (w_room_after_push) begin
                     r_addr <= pc_next(r_fetch_pc);
                  end else begin
                     r_state <= ST_IDLE;
                     r_stb   <= 1'b0;
                  end
               end
            end
            ST_DROP: begin
               if (redirect_in) r_fetch_pc <= redirect_pc_in;
               if (inst_ack_in) begin
                  r_state <= ST_IDLE;
                  r_stb   <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_stb   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instD  <= NOP_INST;
         r_pcD    <= '0;
         r_validD <= 1'b0;
      end else if (redirect_in || flashD) begin
         r_instD  <= NOP_INST;
         r_validD <= 1'b0;
      end else if (!enbD) begin
         if (!w_buf_empty) begin
            r_instD  <= w_head.inst;
            r_pcD    <= w_head.pc;
            r_validD <= 1'b1;
         end else begin
            r_instD  <= NOP_INST;
            r_validD <= 1'b0;
         end
      end
   end

   assign inst_addr_out  = r_addr;
   assign inst_stb_out   = r_stb;
   assign inst_stall_out = w_buf_empty;
   assign instD          = r_instD;
   assign pcD            = r_pcD;
   assign validD         = r_validD;

endmodule
